rs801: RTL and testbench

- 8-bit binary adder with carry-in and carry-out. It is the basic add element of the CPU datapath, used by the ALU and by address/PC increment logic.
- A combinational result path gives `sum`/`cout` in the same cycle.
- An optional registered copy, with status flags, is provided for pipelined consumers.
- Internally built from two 4-bit carry-lookahead groups chained by a group carry.

---
 rtl/rs801.sv | 73 +++++++
 tb/tb_rs801.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rs801.sv
// 8-bit carry-lookahead adder with a combinational result path and an
// optional registered copy that carries the status flags.
module rs801 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic       en,
  output logic [7:0] sum,
  output logic       cout,
  output logic       ovf,
  output logic [7:0] sum_q,
  output logic       cout_q,
  output logic       ovf_q,
  output logic       zero_q,
  output logic       valid_q
);

  // Carries out of each bit of a 4-bit lookahead group: result[i] is the
  // carry into bit i+1, so result[3] is the group carry.
  function automatic logic [3:0] cla4(input logic [3:0] g,
                                      input logic [3:0] p,
                                      input logic       ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  logic [7:0] g;
  logic [7:0] p;
  logic [3:0] c_lo;
  logic [3:0] c_hi;
  logic [7:0] c_in_bit;

  assign g = a & b;
  assign p = a ^ b;

  assign c_lo = cla4(g[3:0], p[3:0], cin);
  assign c_hi = cla4(g[7:4], p[7:4], c_lo[3]);

  assign c_in_bit = {c_hi[2:0], c_lo[3:0], cin};

  assign sum  = p ^ c_in_bit;
  assign cout = c_hi[3];
  assign ovf  = (a[7] == b[7]) && (sum[7] != a[7]);

  // en is a one-shot capture request with no back-pressure; valid_q marks
  // the cycle in which the captured result is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= 8'h00;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        sum_q  <= sum;
        cout_q <= cout;
        ovf_q  <= ovf;
        zero_q <= (sum == 8'h00);
      end
    end
  end

endmodule

// File: tb/tb_rs801.sv
// Directed-vector bench for rs801: table of hand-computed sums, enable/hold
// and reset sequences, and an exhaustive sweep of the combinational path.
module tb_rs801;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       en;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic [7:0] sum_q;
  logic       cout_q;
  logic       ovf_q;
  logic       zero_q;
  logic       valid_q;

  int tests_run;
  int tests_failed;

  rs801 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .en      (en),
    .sum     (sum),
    .cout    (cout),
    .ovf     (ovf),
    .sum_q   (sum_q),
    .cout_q  (cout_q),
    .ovf_q   (ovf_q),
    .zero_q  (zero_q),
    .valid_q (valid_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[12];

  // scoreboard of expected captured sums
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [8:0] act,
                       input logic [8:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      if (tests_failed <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] va, input logic [7:0] vb,
                       input logic vcin, input logic ven);
    a   = va;
    b   = vb;
    cin = vcin;
    en  = ven;
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, " sum_q"},   {1'b0, sum_q},   9'h000);
    check({tag, " cout_q"},  {8'h0, cout_q},  9'h000);
    check({tag, " ovf_q"},   {8'h0, ovf_q},   9'h000);
    check({tag, " zero_q"},  {8'h0, zero_q},  9'h000);
    check({tag, " valid_q"}, {8'h0, valid_q}, 9'h000);
  endtask

  initial begin
    logic [8:0] full;
    logic       exp_ovf;
    logic [7:0] exp_s;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0]  = '{8'h2A, 8'h15, 1'b0, 8'h3F, 1'b0, 1'b0};
    vecs[1]  = '{8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[8]  = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[10] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[11] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};

    // reset state, with the combinational path live during reset
    rst_n = 1'b0;
    drive(8'h12, 8'h34, 1'b0, 1'b1);
    #2;
    check_regs_zero("reset");
    check("reset comb sum", {cout, sum}, 9'h046);
    @(posedge clk);
    #1;
    check("reset clocked valid_q", {8'h0, valid_q}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;

    // table-driven vectors: comb, then registered after one capture edge
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
      #1;
      check($sformatf("vec%0d sum", i), {1'b0, sum}, {1'b0, vecs[i].exp_sum});
      check($sformatf("vec%0d cout", i), {8'h0, cout}, {8'h0, vecs[i].exp_cout});
      check($sformatf("vec%0d ovf", i), {8'h0, ovf}, {8'h0, vecs[i].exp_ovf});
      exp_q.push_back(vecs[i].exp_sum);
      tick();
      en = 1'b0;
      exp_s = exp_q.pop_front();
      check($sformatf("vec%0d sum_q", i), {1'b0, sum_q}, {1'b0, exp_s});
      check($sformatf("vec%0d cout_q", i), {8'h0, cout_q}, {8'h0, vecs[i].exp_cout});
      check($sformatf("vec%0d ovf_q", i), {8'h0, ovf_q}, {8'h0, vecs[i].exp_ovf});
      check($sformatf("vec%0d zero_q", i), {8'h0, zero_q},
            {8'h0, (vecs[i].exp_sum == 8'h00)});
      check($sformatf("vec%0d valid_q", i), {8'h0, valid_q}, 9'h001);
    end

    // back-to-back captures: one result per cycle
    @(negedge clk);
    drive(8'h01, 8'h02, 1'b0, 1'b1);
    tick();
    check("b2b first sum_q", {1'b0, sum_q}, 9'h003);
    drive(8'h10, 8'h01, 1'b1, 1'b1);
    tick();
    check("b2b second sum_q", {1'b0, sum_q}, 9'h012);
    check("b2b second valid_q", {8'h0, valid_q}, 9'h001);

    // enable/hold: capture 0x3F, then three cycles with en=0
    @(negedge clk);
    drive(8'h2A, 8'h15, 1'b0, 1'b1);
    tick();
    check("hold capture sum_q", {1'b0, sum_q}, 9'h03F);
    for (int k = 0; k < 3; k++) begin
      drive(8'h10 * (k + 1), 8'h03, 1'b1, 1'b0);
      tick();
      check($sformatf("hold%0d sum_q", k), {1'b0, sum_q}, 9'h03F);
      check($sformatf("hold%0d valid_q", k), {8'h0, valid_q}, 9'h000);
      check($sformatf("hold%0d comb", k), {cout, sum},
            {1'b0, 8'(8'h10 * (k + 1) + 8'h04)});
    end

    // reset mid-stream between edges, then a coincident-edge capture attempt
    @(negedge clk);
    drive(8'h2A, 8'h15, 1'b0, 1'b1);
    tick();
    check("pre-reset sum_q", {1'b0, sum_q}, 9'h03F);
    drive(8'hC8, 8'h64, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_regs_zero("async reset");
    check("reset comb C8+64", {cout, sum}, 9'h12C);
    @(posedge clk);
    #1;
    check_regs_zero("reset held edge");
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h10, 8'h20, 1'b0, 1'b1);
    tick();
    en = 1'b0;
    check("post-reset sum_q", {1'b0, sum_q}, 9'h030);
    check("post-reset valid_q", {8'h0, valid_q}, 9'h001);

    // exhaustive combinational sweep
    en = 1'b0;
    for (int x = 0; x < 512; x++) begin
      for (int y = 0; y < 256; y++) begin
        a   = x[7:0];
        b   = y[7:0];
        cin = x[8];
        #1;
        full    = {1'b0, x[7:0]} + {1'b0, y[7:0]} + {8'h0, x[8]};
        exp_ovf = (x[7] == y[7]) && (full[7] != x[7]);
        check($sformatf("sweep %0h+%0h+%0d", x[7:0], y[7:0], x[8]),
              {cout, sum}, full);
        check($sformatf("sweep ovf %0h+%0h+%0d", x[7:0], y[7:0], x[8]),
              {8'h0, ovf}, {8'h0, exp_ovf});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
